// File: rtl/audio_tdm_serializer.sv
// audio_tdm_serializer: serial audio transmitter producing standard 2-channel I2S
// or N-slot TDM (DSP mode A) from multi-channel frames offered through a
// 1-entry holding buffer.
// Optional feature: define AUDIO_DSM_EN to enable first-order delta-sigma
// outputs on dsm_l / dsm_r; otherwise both outputs are tied low.
module audio_tdm_serializer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int CHANNELS     = 2,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCK_DIV      = 8,
    parameter int TDM_MODE     = 0
) (
    input  logic                             clk_sys,
    input  logic                             reset_n,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_data,
    input  logic                             sample_valid,
    output logic                             sample_ready,
    output logic                             i2s_bck,
    output logic                             i2s_lrck,
    output logic                             i2s_data,
    output logic                             frame_start,
    output logic                             underrun,
    output logic                             dsm_l,
    output logic                             dsm_r
);
    localparam int FW     = CHANNELS * SAMPLE_WIDTH;
    localparam int DIV_W  = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int SLOT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int POS_W  = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam int IDX_W  = (FW > 1) ? $clog2(FW) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNELS - 1);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(SLOT_WIDTH - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [SLOT_W-1:0] slot_idx, slot_n, slot_after;
    logic [POS_W-1:0]  pos_idx, pos_n;
    logic [FW-1:0]     frame_reg, frame_n, holding;
    logic              holding_full;
    logic              tick, bck_fall, last_pos, last_slot, load, accept;
    logic              in_sample, data_n, lrck_n;
    logic [IDX_W-1:0]  bit_sel;

    assign sample_ready = !holding_full;

    // Bit index b is kept as (slot, position) so no divider is needed for b / SLOT_WIDTH
    always_comb begin
        tick      = (div_cnt == DIV_LAST);
        bck_fall  = tick && i2s_bck;
        last_pos  = (pos_idx == POS_LAST);
        last_slot = (slot_idx == SLOT_LAST);
        load      = bck_fall && last_pos && last_slot;
        accept    = sample_valid && !holding_full;
        pos_n     = last_pos ? '0 : pos_idx + 1'b1;
        slot_n    = slot_idx;
        if (last_pos) begin
            slot_n = last_slot ? '0 : slot_idx + 1'b1;
        end
        frame_n = frame_reg;
        if (load) begin
            frame_n = holding_full ? holding : '0;
        end
    end

    // Serial bit and word select for the index reached on this falling edge;
    // the bit for b = 0 comes from the frame being loaded in the same cycle
    always_comb begin
        in_sample = (int'(pos_n) < SAMPLE_WIDTH);
        bit_sel   = '0;
        data_n    = 1'b0;
        if (in_sample) begin
            bit_sel = IDX_W'(int'(slot_n) * SAMPLE_WIDTH + (SAMPLE_WIDTH - 1) - int'(pos_n));
            data_n  = frame_n[bit_sel];
        end
        slot_after = slot_n;
        if (pos_n == POS_LAST) begin
            slot_after = (slot_n == SLOT_LAST) ? '0 : slot_n + 1'b1;
        end
        if (TDM_MODE != 0) begin
            lrck_n = (pos_n == POS_LAST) && (slot_n == SLOT_LAST);
        end else begin
            lrck_n = (slot_after != '0);
        end
    end

    // BCK divider: toggle the bit clock on each terminal count
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            i2s_bck <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            i2s_bck <= ~i2s_bck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Bit index and serial outputs advance together on the BCK falling edge
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            slot_idx <= SLOT_LAST;
            pos_idx  <= POS_LAST;
            i2s_lrck <= 1'b0;
            i2s_data <= 1'b0;
        end else if (bck_fall) begin
            slot_idx <= slot_n;
            pos_idx  <= pos_n;
            i2s_lrck <= lrck_n;
            i2s_data <= data_n;
        end
    end

    // Frame register load and per-frame status pulses
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            frame_reg   <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_reg   <= frame_n;
            frame_start <= load;
            underrun    <= load && !holding_full;
        end
    end

    // One-entry holding buffer; a load and an accept in the same cycle leave it full
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            holding      <= '0;
            holding_full <= 1'b0;
        end else begin
            if (accept) begin
                holding <= sample_data;
            end
            holding_full <= (holding_full && !load) || accept;
        end
    end

`ifdef AUDIO_DSM_EN
    localparam int R_CH = (CHANNELS > 1) ? 1 : 0;
    localparam logic [SAMPLE_WIDTH-1:0] MSB_FLIP = SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);

    logic [SAMPLE_WIDTH-1:0] dsm_in_l, dsm_in_r;
    logic [SAMPLE_WIDTH:0]   acc_l, acc_r;

    // Offset-binary modulator inputs latched from each newly loaded frame
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dsm_in_l <= '0;
            dsm_in_r <= '0;
        end else if (load) begin
            dsm_in_l <= frame_n[0 +: SAMPLE_WIDTH] ^ MSB_FLIP;
            dsm_in_r <= frame_n[R_CH*SAMPLE_WIDTH +: SAMPLE_WIDTH] ^ MSB_FLIP;
        end
    end

    // First-order accumulators; the carry out is the 1-bit output stream
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_l <= '0;
            acc_r <= '0;
        end else begin
            acc_l <= {1'b0, acc_l[SAMPLE_WIDTH-1:0]} + {1'b0, dsm_in_l};
            acc_r <= {1'b0, acc_r[SAMPLE_WIDTH-1:0]} + {1'b0, dsm_in_r};
        end
    end

    assign dsm_l = acc_l[SAMPLE_WIDTH];
    assign dsm_r = acc_r[SAMPLE_WIDTH];
`else
    assign dsm_l = 1'b0;
    assign dsm_r = 1'b0;
`endif

endmodule
